// File: rtl/reg_if_loader_pkg.sv
// reg_if_loader_pkg: register-interface constants and loader types shared by the loader, its interface and benches.
package reg_if_loader_pkg;
   localparam int REG_WIDTH        = 32;
   localparam int ADDR_WIDTH       = 11;
   localparam int RD_LATENCY       = 2;
   localparam int LOADER_MAX_WORDS = 2 ** ADDR_WIDTH;
   localparam logic [REG_WIDTH-1:0] CMD_NOP     = 32'd0;
   localparam logic [REG_WIDTH-1:0] CMD_WRITE   = 32'd1;
   localparam logic [REG_WIDTH-1:0] CMD_READ    = 32'd2;
   localparam logic [REG_WIDTH-1:0] STATUS_IDLE = 32'd0;
   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} loader_state_t;
endpackage

// File: rtl/reg_if_loader_if.sv
// reg_if_loader_if: program-word stream plus instruction-memory register bus seen by the loader.
interface reg_if_loader_if;
   import reg_if_loader_pkg::*;
   logic                 s_valid;
   logic                 s_ready;
   logic                 s_last;
   logic [REG_WIDTH-1:0] s_data;
   logic [REG_WIDTH-1:0] data_in_register;
   logic [REG_WIDTH-1:0] address_register;
   logic [REG_WIDTH-1:0] cmd_register;
   logic [REG_WIDTH-1:0] status_register;
   logic [REG_WIDTH-1:0] data_o_register;
   modport master (
      input  s_valid, s_data, s_last, status_register, data_o_register,
      output s_ready, data_in_register, address_register, cmd_register
   );
   modport slave (
      output s_valid, s_data, s_last, status_register, data_o_register,
      input  s_ready, data_in_register, address_register, cmd_register
   );
endinterface

// File: rtl/reg_if_loader.sv
// reg_if_loader: turns a valid/ready word stream into single-cycle register-interface writes.
// Define REG_IF_LOADER_VERIFY_EN to add a read-back pass against a shadow copy of the low 16 bits.
module reg_if_loader
   import reg_if_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   reg_if_loader_if.master       bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_written
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LOADER_MAX_WORDS - 1);
   loader_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, radr_q, radr_d;
   logic [REG_WIDTH-1:0]  data_q, data_d, cmd_q, cmd_d;
   logic                  ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [ADDR_WIDTH:0]   ww_q, ww_d;
   logic                  accept;
   assign accept = bus.s_valid & ready_q;
`ifdef REG_IF_LOADER_VERIFY_EN
   localparam int LAT_W = $clog2(RD_LATENCY + 2);
   localparam logic [LAT_W-1:0] LAT_CMP = LAT_W'(RD_LATENCY + 1);
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   vidx_q, vidx_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic [15:0]           shadow_q [LOADER_MAX_WORDS];
   logic                  unused_rd;
   assign unused_rd = ^bus.data_o_register[REG_WIDTH-1:16];
   always_ff @(posedge clk)
      if (state_q == WRITE && accept) shadow_q[addr_q] <= bus.s_data[15:0];
   always_ff @(posedge clk)
      if (reset) {base_q, vidx_q, lat_q} <= '0;
      else {base_q, vidx_q, lat_q} <= {base_d, vidx_d, lat_d};
`else
   logic unused_rd;
   assign unused_rd = ^bus.data_o_register;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         radr_q  <= '0;
         data_q  <= '0;
         cmd_q   <= CMD_NOP;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ww_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         radr_q  <= radr_d;
         data_q  <= data_d;
         cmd_q   <= cmd_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ww_q    <= ww_d;
      end
   end
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      radr_d  = radr_q;
      data_d  = data_q;
      cmd_d   = CMD_NOP;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      ww_d    = ww_q;
`ifdef REG_IF_LOADER_VERIFY_EN
      base_d  = base_q;
      vidx_d  = vidx_q;
      lat_d   = lat_q;
`endif
      case (state_q)
         IDLE: if (start && bus.status_register == STATUS_IDLE) begin
            state_d = WRITE;
            addr_d  = base_addr;
            ww_d    = '0;
            err_d   = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b1;
`ifdef REG_IF_LOADER_VERIFY_EN
            base_d  = base_addr;
            vidx_d  = '0;
            lat_d   = '0;
`endif
         end
         WRITE: if (accept) begin
            radr_d = addr_q;
            data_d = bus.s_data;
            cmd_d  = CMD_WRITE;
            ww_d   = ww_q + 1'b1;
            // the top address ends the load instead of wrapping; without s_last that is an overflow
            if (bus.s_last || addr_q == ADDR_LAST) begin
               ready_d = 1'b0;
               err_d   = ~bus.s_last;
`ifdef REG_IF_LOADER_VERIFY_EN
               state_d = VERIFY;
`else
               state_d = DONE;
`endif
            end else addr_d = addr_q + 1'b1;
         end
`ifdef REG_IF_LOADER_VERIFY_EN
         VERIFY: begin
            cmd_d  = CMD_READ;
            radr_d = base_q + vidx_q[ADDR_WIDTH-1:0];
            lat_d  = lat_q + 1'b1;
            // lat_q 0 issues the read; data_o is valid once RD_LATENCY cycles of READ have elapsed
            if (lat_q == LAT_CMP) begin
               cmd_d  = CMD_NOP;
               lat_d  = '0;
               vidx_d = vidx_q + 1'b1;
               if (bus.data_o_register[15:0] != shadow_q[radr_q]) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (vidx_q + 1'b1 == ww_q) state_d = DONE;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   assign bus.s_ready          = ready_q;
   assign bus.data_in_register = data_q;
   assign bus.address_register = {{(REG_WIDTH-ADDR_WIDTH){1'b0}}, radr_q};
   assign bus.cmd_register     = cmd_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign error                = err_q;
   assign words_written        = ww_q;
endmodule

// File: tb/tb_reg_if_loader.sv
// tb_reg_if_loader: directed and randomized loads checked every cycle against a transaction-level model.
module tb_reg_if_loader;
   import reg_if_loader_pkg::*;
   localparam logic [ADDR_WIDTH-1:0] CORRUPT_ADDR = 11'h011;
   localparam logic [ADDR_WIDTH-1:0] TOP_ADDR     = ADDR_WIDTH'(LOADER_MAX_WORDS - 1);
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [ADDR_WIDTH-1:0] base_addr = '0;
   logic busy, done, error;
   logic [ADDR_WIDTH:0] words_written;
   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;
   bit corrupt_en = 1'b0;
   logic [ADDR_WIDTH+REG_WIDTH-1:0] wlog [$];
   reg_if_loader_if bus ();
   reg_if_loader dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .bus(bus),
      .busy(busy), .done(done), .error(error), .words_written(words_written)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [REG_WIDTH-1:0] act, input logic [REG_WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_log(input int i, input logic [ADDR_WIDTH-1:0] a, input logic [REG_WIDTH-1:0] d);
      logic [ADDR_WIDTH+REG_WIDTH-1:0] e, got;
      e = {a, d};
      got = (i < wlog.size()) ? wlog[i] : '1;
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL write_log[%0d] actual=0x%0h required=0x%0h", i, got, e);
      end
   endtask
   // memory behind the register interface: writes land immediately, reads return RD_LATENCY cycles later
   logic [15:0] mem [LOADER_MAX_WORDS];
   logic [REG_WIDTH-1:0] rd_p1 = '0;
   always @(posedge clk) begin
      if (bus.cmd_register == CMD_WRITE) mem[bus.address_register[ADDR_WIDTH-1:0]] <= bus.data_in_register[15:0];
      rd_p1 <= {16'h0, mem[bus.address_register[ADDR_WIDTH-1:0]] ^
                {15'h0, corrupt_en && bus.address_register[ADDR_WIDTH-1:0] == CORRUPT_ADDR}};
      bus.data_o_register <= rd_p1;
   end
   // transaction-level model: each accepted word becomes one write of {next address, word} on the next cycle
   bit m_busy, m_ready, m_done, m_err, m_fin, m_verify, m_bad, m_ad_known;
   int m_ww = 0;
   logic [ADDR_WIDTH-1:0] m_next;
   logic [REG_WIDTH-1:0] m_cmd, m_addr, m_data;
   always @(posedge clk) begin
      m_cmd  = CMD_NOP;
      m_done = 1'b0;
      if (reset) begin
         m_busy = 0; m_ready = 0; m_err = 0; m_fin = 0; m_verify = 0; m_bad = 0;
         m_ad_known = 1; m_ww = 0; m_addr = '0; m_data = '0;
      end else if (m_verify) begin
         if (done) begin
            m_verify = 0;
            m_busy   = 0;
            m_err    = m_err | m_bad;
         end
      end else if (m_fin) begin
         m_fin = 0;
`ifdef REG_IF_LOADER_VERIFY_EN
         m_verify   = 1;
         m_ad_known = 0;
`else
         m_busy = 0;
         m_done = 1;
`endif
      end else if (!m_busy) begin
         if (start && bus.status_register == STATUS_IDLE) begin
            m_busy = 1; m_ready = 1; m_next = base_addr; m_ww = 0; m_err = 0; m_bad = 0;
         end
      end else if (m_ready && bus.s_valid) begin
         m_cmd      = CMD_WRITE;
         m_addr     = REG_WIDTH'(m_next);
         m_data     = bus.s_data;
         m_ad_known = 1;
         m_ww++;
         m_bad = m_bad | (corrupt_en && m_next == CORRUPT_ADDR);
         if (bus.s_last || m_next == TOP_ADDR) begin
            m_ready = 0;
            m_fin   = 1;
            m_err   = !bus.s_last;
         end else m_next++;
      end
   end
   always @(negedge clk) if (chk_en) begin
      chk("s_ready", bus.s_ready, m_ready);
      chk("words_written", words_written, m_ww);
      if (!m_verify) begin
         chk("cmd", bus.cmd_register, m_cmd);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("error", error, m_err);
         if (m_ad_known) begin
            chk("address", bus.address_register, m_addr);
            chk("data", bus.data_in_register, m_data);
         end
      end
      if (bus.cmd_register == CMD_WRITE)
         wlog.push_back({bus.address_register[ADDR_WIDTH-1:0], bus.data_in_register});
   end
   task automatic cyc(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask
   task automatic pulse_start(input logic [ADDR_WIDTH-1:0] b);
      base_addr = b;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask
   task automatic send(input logic [REG_WIDTH-1:0] d, input bit last, input int gap, input int tmo, output bit ok);
      bus.s_valid = 1'b0;
      bus.s_data  = $urandom;
      cyc(gap);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      ok = 1'b0;
      for (int i = 0; i < tmo && !ok; i++) begin
         ok = bus.s_ready;
         cyc(1);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask
   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         seen = done;
         if (!seen) cyc(1);
      end
      chk(name, seen, 1);
   endtask
   task automatic wait_idle(input string name);
      bit idle = 1'b0;
      for (int i = 0; i < 200 && !idle; i++) begin
         idle = !m_busy && !m_verify && !m_fin;
         if (!idle) cyc(1);
      end
      chk(name, idle, 1);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
   initial begin
      bit ok;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.status_register = STATUS_IDLE;
      cyc(2);
      chk_en = 1'b1;
      chk("rst_cmd", bus.cmd_register, CMD_NOP);
      chk("rst_ready", bus.s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ww", words_written, 0);
      chk("rst_addr", bus.address_register, 0);
      reset = 1'b0;
      wlog.delete();
      pulse_start(11'h010);
      chk("start_busy", busy, 1);
      send(32'hDEADBEEF, 0, 0, 20, ok);
      send(32'h01020304, 0, 0, 20, ok);
      send(32'hA5A5A5A5, 1, 0, 20, ok);
      wait_done("basic_done");
      chk("basic_ww", words_written, 3);
      chk("basic_err", error, 0);
      chk("basic_busy", busy, 0);
      chk_log(0, 11'h010, 32'hDEADBEEF);
      chk_log(1, 11'h011, 32'h01020304);
      chk_log(2, 11'h012, 32'hA5A5A5A5);
      cyc(2);
      wlog.delete();
      pulse_start(11'h100);
      send(32'h11111111, 0, 2, 20, ok);
      send(32'h22222222, 0, 2, 20, ok);
      send(32'h33333333, 1, 2, 20, ok);
      wait_done("gap_done");
      chk("gap_ww", words_written, 3);
      chk_log(0, 11'h100, 32'h11111111);
      chk_log(1, 11'h101, 32'h22222222);
      chk_log(2, 11'h102, 32'h33333333);
      cyc(2);
      wlog.delete();
      pulse_start(11'h7FE);
      send(32'hCAFE0001, 0, 0, 20, ok);
      send(32'hCAFE0002, 0, 0, 20, ok);
      chk("ovf_second_accepted", ok, 1);
      send(32'hCAFE0003, 0, 0, 8, ok);
      chk("ovf_third_rejected", ok, 0);
      wait_idle("ovf_idle");
      chk("ovf_ww", words_written, 2);
      chk("ovf_err", error, 1);
      chk_log(0, 11'h7FE, 32'hCAFE0001);
      chk_log(1, 11'h7FF, 32'hCAFE0002);
      chk("ovf_log_len", wlog.size(), 2);
      cyc(2);
      bus.status_register = 32'h5;
      pulse_start(11'h020);
      cyc(2);
      chk("gate_busy", busy, 0);
      chk("gate_ready", bus.s_ready, 0);
      chk("gate_err_kept", error, 1);
      bus.status_register = STATUS_IDLE;
      wlog.delete();
      pulse_start(11'h200);
      send(32'h0BADF00D, 0, 0, 20, ok);
      pulse_start(11'h300);
      send(32'h600DF00D, 1, 0, 20, ok);
      wait_done("busy_start_done");
      chk_log(0, 11'h200, 32'h0BADF00D);
      chk_log(1, 11'h201, 32'h600DF00D);
      chk("busy_start_ww", words_written, 2);
      cyc(2);
      pulse_start(11'h040);
      send(32'h40404040, 0, 0, 20, ok);
      send(32'h41414141, 0, 0, 20, ok);
      reset = 1'b1;
      cyc(1);
      chk("midrst_cmd", bus.cmd_register, CMD_NOP);
      chk("midrst_ready", bus.s_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ww", words_written, 0);
      reset = 1'b0;
      cyc(1);
`ifdef REG_IF_LOADER_VERIFY_EN
      corrupt_en = 1'b1;
      pulse_start(11'h010);
      send(32'h00000010, 0, 0, 20, ok);
      send(32'h00000011, 0, 0, 20, ok);
      send(32'h00000012, 1, 0, 20, ok);
      wait_done("verify_done");
      chk("verify_err", error, 1);
      corrupt_en = 1'b0;
      cyc(2);
`endif
      for (int n = 0; n < 40; n++) begin
         int len;
         logic [ADDR_WIDTH-1:0] b;
         if ($urandom_range(0, 3) == 0) begin
            bus.status_register = REG_WIDTH'($urandom_range(1, 7));
            pulse_start(ADDR_WIDTH'($urandom));
            cyc(1);
            bus.status_register = STATUS_IDLE;
         end
         b = ($urandom_range(0, 3) == 0) ? ADDR_WIDTH'($urandom_range(2040, 2047)) : ADDR_WIDTH'($urandom);
         len = $urandom_range(1, 6);
         pulse_start(b);
         for (int i = 0; i < len && m_busy && m_ready && !m_fin; i++) begin
            send($urandom, i == len - 1, $urandom_range(0, 2), 20, ok);
            if ($urandom_range(0, 4) == 0) pulse_start(ADDR_WIDTH'($urandom));
         end
         wait_idle("rand_idle");
         cyc($urandom_range(0, 2));
      end
      cyc(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
